multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Control unit for the multicycle MIPS datapath; successor to the single-cycle control path.
- A registered Moore FSM sequences each instruction over 3-5 states and drives the shared-ALU/shared-memory datapath.
- Adds a variable-latency memory handshake, optional bne, and illegal-opcode and retire pulses.
- Sits between the instruction register (op, funct), the ALU zero flag and the datapath muxes and enables.

Parameters:
ALUCTRL_W, 3, width of alucontrol; must be >=3; upper bits zero-filled
SUPPORT_BNE, 1, 1 = opcode 000101 executes as bne; 0 = treated as illegal

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-low; state cleared on a clk edge where reset=0
op  in  6  instruction opcode from instruction register
funct  in  6  R-type function field
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes access this cycle; meaningful only while mem_req=1
mem_req  out  1  memory access request
iord  out  1  0 = PC addresses memory, 1 = ALUOut
memwrite  out  1  store strobe, qualified by mem_req
irwrite  out  1  instruction register load
regdst  out  1  1 = rd, 0 = rt
memtoreg  out  1  1 = write back Data register
regwrite  out  1  register file write
alusrca  out  1  0 = PC, 1 = A
alusrcb  out  2  00 B, 01 const 4, 10 signimm, 11 signimm<<2
pcsrc  out  2  00 ALUResult, 01 ALUOut, 10 jump target
pcen  out  1  PC register enable
alucontrol  out  ALUCTRL_W  ALU operation
instr_done  out  1  one-cycle pulse on the last cycle of each instruction
illegal  out  1  one-cycle pulse in DECODE on an unsupported opcode

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP.
- State register is the only sequential element. Outputs are combinational from state, plus op/funct/zero/mem_ready where stated below.
- Reset (reset=0 at edge): state <= FETCH. While reset=0, all outputs are forced to 0 (mem_req, memwrite, irwrite, regwrite, pcen, instr_done, illegal). Reset in any state, including mid-wait, aborts the instruction; no write is issued in that cycle.
- FETCH:
  - mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=add, pcsrc=00.
  - If mem_ready: irwrite=1, pcen=1, next state DECODE.
  - Otherwise hold FETCH with irwrite=pcen=0.
- DECODE: alusrca=0, alusrcb=11, aluop=add (branch target into ALUOut). Next state by op:
  - 100011/101011 -> MEMADR
  - 000000 -> EXECUTE
  - 000100 -> BRANCH
  - 000101 -> BRANCH if SUPPORT_BNE, else illegal
  - 001000 -> ADDIEXEC
  - 000010 -> JUMP
  - any other opcode -> illegal=1, instr_done=1, next state FETCH; no architectural write.
- MEMADR: alusrca=1, alusrcb=10, aluop=add. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, iord=1. Wait for mem_ready, then MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1, instr_done=1. Next state FETCH.
- MEMWR: mem_req=1, iord=1, memwrite=1, held stable until mem_ready. In the mem_ready cycle: instr_done=1, next state FETCH.
- EXECUTE: alusrca=1, alusrcb=00, aluop=funct. Next state ALUWB.
- ALUWB: regdst=1, regwrite=1, instr_done=1. Next state FETCH.
- BRANCH:
  - alusrca=1, alusrcb=00, aluop=sub, pcsrc=01.
  - pcen = zero for beq, ~zero for bne.
  - instr_done=1; next state FETCH.
- ADDIEXEC: alusrca=1, alusrcb=10, aluop=add. Next state ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1, instr_done=1. Next state FETCH.
- JUMP: pcsrc=10, pcen=1, instr_done=1. Next state FETCH.
- ALU decode:
  - aluop add -> 010, sub -> 110.
  - funct decode: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, other -> 000.
  - The result is zero-extended to ALUCTRL_W.
- Invariants:
  - Outputs not listed for a state are 0.
  - At most one of regwrite/memwrite/irwrite is high per cycle.
  - mem_ready while mem_req=0 is ignored.
- Latencies with mem_ready tied high: lw 5 cycles, sw 4, R-type 4, addi 4, beq/bne 3, j 3. Each extra wait cycle adds 1.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum (4-bit encoding)
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J
  - funct constants
  - aluop_t (add, sub, funct)
- Sub-module: the existing aludec, instantiated for the ALU decode with width extension done in this block.
- FSM next-state and output logic stay in this module.

Test Plan:
- reset=0 for 2 cycles mid-MEMWR with mem_ready=0 -> memwrite=0 during reset; state FETCH after reset=1; first cycle mem_req=1, iord=0.
- lw (op=100011), mem_ready=1 always -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1, memtoreg=1 only in cycle 5; instr_done pulses once.
- sw with mem_ready low for 3 cycles in MEMWR -> memwrite=1, iord=1 held 4 cycles; instr_done only in the mem_ready cycle; total 7 cycles.
- beq zero=1, then bne zero=1 (SUPPORT_BNE=1) -> pcen=1, pcsrc=01 for beq; pcen=0 for bne; both 3 cycles.
- R-type funct=101010 with ALUCTRL_W=4 -> alucontrol=4'b0111 in EXECUTE; ALUWB regdst=1, regwrite=1.
- op=111111, and op=000101 with SUPPORT_BNE=0 -> illegal=1 and instr_done=1 in DECODE; next cycle FETCH; no regwrite/memwrite/pcen beyond fetch.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mc_ctrl_pkg : shared types and encodings for the multicycle MIPS controller
// Rev 1.0
// ---------------------------------------------------------------------------
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage
`default_nettype wire

// File: rtl/multicycle_controller_aludec.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aludec : maps the FSM's ALU operation class and funct field to a 3-bit op
// Rev 1.0
// ---------------------------------------------------------------------------
module aludec
  import mc_ctrl_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_AND;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      default: begin
        case (funct)
          FUNCT_ADD: alucontrol = ALU_ADD;
          FUNCT_SUB: alucontrol = ALU_SUB;
          FUNCT_AND: alucontrol = ALU_AND;
          FUNCT_OR:  alucontrol = ALU_OR;
          FUNCT_SLT: alucontrol = ALU_SLT;
          default:   alucontrol = ALU_AND;
        endcase
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multicycle_controller : Moore FSM driving the shared-ALU/shared-memory MIPS
// datapath, with a variable-latency memory handshake. Rev 1.0
// ---------------------------------------------------------------------------
module multicycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W   = 3,
  parameter bit SUPPORT_BNE = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 iord,
  output logic                 memwrite,
  output logic                 irwrite,
  output logic                 regdst,
  output logic                 memtoreg,
  output logic                 regwrite,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic [1:0]           pcsrc,
  output logic                 pcen,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 instr_done,
  output logic                 illegal
);

  state_t state_q, state_d;
  aluop_t aluop;
  logic   alu_en;
  logic [2:0]           alu_ctrl3;
  logic [ALUCTRL_W-1:0] alu_ctrl_ext;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    pcen       = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    aluop      = ALUOP_ADD;
    alu_en     = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = 2'b01;
        alu_en  = 1'b1;
        if (mem_ready) begin
          irwrite = 1'b1;
          pcen    = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        alu_en  = 1'b1;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          OP_BNE: begin
            if (SUPPORT_BNE) begin
              state_d = S_BRANCH;
            end else begin
              illegal    = 1'b1;
              instr_done = 1'b1;
              state_d    = S_FETCH;
            end
          end
          default: begin
            illegal    = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        alu_en  = 1'b1;
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        // Store strobe stays asserted with a stable address until memory accepts it.
        mem_req  = 1'b1;
        iord     = 1'b1;
        memwrite = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
        alu_en  = 1'b1;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        aluop      = ALUOP_SUB;
        alu_en     = 1'b1;
        pcsrc      = 2'b01;
        pcen       = (SUPPORT_BNE && (op == OP_BNE)) ? ~zero : zero;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        alu_en  = 1'b1;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pcsrc      = 2'b10;
        pcen       = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset overrides everything so an aborted instruction can never write.
    if (!reset) begin
      state_d    = S_FETCH;
      mem_req    = 1'b0;
      iord       = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      pcen       = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
      alu_en     = 1'b0;
    end
  end

  aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alu_ctrl3)
  );

  if (ALUCTRL_W > 3) begin : g_alu_ext
    assign alu_ctrl_ext = {{(ALUCTRL_W-3){1'b0}}, alu_ctrl3};
  end else begin : g_alu_exact
    assign alu_ctrl_ext = alu_ctrl3[ALUCTRL_W-1:0];
  end

  assign alucontrol = alu_en ? alu_ctrl_ext : '0;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_multicycle_controller : directed vector bench for multicycle_controller
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, zero, mem_ready;
  logic [5:0] op, funct;
  logic       mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic       pcen, instr_done, illegal;
  logic [3:0] alucontrol;

  logic       nb_reset, nb_mem_ready;
  logic [5:0] nb_op;
  logic       nb_mem_req, nb_iord, nb_memwrite, nb_irwrite, nb_regdst, nb_memtoreg;
  logic       nb_regwrite, nb_alusrca, nb_pcen, nb_instr_done, nb_illegal;
  logic [1:0] nb_alusrcb, nb_pcsrc;
  logic [2:0] nb_alucontrol;

  multicycle_controller #(.ALUCTRL_W(4), .SUPPORT_BNE(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .pcen(pcen), .alucontrol(alucontrol),
    .instr_done(instr_done), .illegal(illegal)
  );

  multicycle_controller #(.ALUCTRL_W(3), .SUPPORT_BNE(1'b0)) dut_nb (
    .clk(clk), .reset(nb_reset), .op(nb_op), .funct(funct), .zero(zero), .mem_ready(nb_mem_ready),
    .mem_req(nb_mem_req), .iord(nb_iord), .memwrite(nb_memwrite), .irwrite(nb_irwrite),
    .regdst(nb_regdst), .memtoreg(nb_memtoreg), .regwrite(nb_regwrite), .alusrca(nb_alusrca),
    .alusrcb(nb_alusrcb), .pcsrc(nb_pcsrc), .pcen(nb_pcen), .alucontrol(nb_alucontrol),
    .instr_done(nb_instr_done), .illegal(nb_illegal)
  );

  logic [18:0] act, nb_act;
  assign act = {mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                alusrcb, pcsrc, pcen, alucontrol, instr_done, illegal};
  assign nb_act = {nb_mem_req, nb_iord, nb_memwrite, nb_irwrite, nb_regdst, nb_memtoreg,
                   nb_regwrite, nb_alusrca, nb_alusrcb, nb_pcsrc, nb_pcen,
                   1'b0, nb_alucontrol, nb_instr_done, nb_illegal};

  typedef struct {
    string       nm;
    bit          rst_n;
    logic [5:0]  op;
    logic [5:0]  funct;
    bit          zero;
    bit          rdy;
    logic [18:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  // Field order: mem_req iord memwrite irwrite regdst memtoreg regwrite alusrca
  //              alusrcb pcsrc pcen alucontrol instr_done illegal
  function automatic logic [18:0] o(input bit mr, io, mw, ir, rd, mt, rw, sa,
                                    input logic [1:0] sb, ps, input bit pe,
                                    input logic [3:0] ac, input bit dn, il);
    return {mr, io, mw, ir, rd, mt, rw, sa, sb, ps, pe, ac, dn, il};
  endfunction

  function automatic void add(input string nm, input bit r, input logic [5:0] op_v,
                              input logic [5:0] fn, input bit z, input bit rdy,
                              input logic [18:0] e);
    vec_t v;
    v.nm = nm; v.rst_n = r; v.op = op_v; v.funct = fn; v.zero = z; v.rdy = rdy; v.exp = e;
    vecs.push_back(v);
  endfunction

  task automatic compare(input string nm, input logic [18:0] got, input logic [18:0] e);
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, got, e);
    end
  endtask

  task automatic step_main(input string nm, input bit r, input logic [5:0] op_v,
                           input logic [5:0] fn, input bit z, input bit rdy,
                           input logic [18:0] e);
    @(negedge clk);
    reset = r; op = op_v; funct = fn; zero = z; mem_ready = rdy;
    #1;
    compare(nm, act, e);
  endtask

  task automatic step_nb(input string nm, input bit r, input logic [5:0] op_v,
                         input bit rdy, input logic [18:0] e);
    @(negedge clk);
    nb_reset = r; nb_op = op_v; nb_mem_ready = rdy;
    #1;
    compare(nm, nb_act, e);
  endtask

  logic [18:0] ZERO, F_RDY, F_WAIT, DEC, DEC_ILL, MADR, MRD, MWB, MWR_W, MWR_D;
  logic [18:0] BR_T, BR_N, ALUWB, ADDX, ADDWB, JMP;

  initial begin
    reset = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;
    nb_reset = 1'b0; nb_op = 6'd0; nb_mem_ready = 1'b0;

    ZERO    = '0;
    F_RDY   = o(1,0,0,1,0,0,0,0,2'b01,2'b00,1,4'b0010,0,0);
    F_WAIT  = o(1,0,0,0,0,0,0,0,2'b01,2'b00,0,4'b0010,0,0);
    DEC     = o(0,0,0,0,0,0,0,0,2'b11,2'b00,0,4'b0010,0,0);
    DEC_ILL = o(0,0,0,0,0,0,0,0,2'b11,2'b00,0,4'b0010,1,1);
    MADR    = o(0,0,0,0,0,0,0,1,2'b10,2'b00,0,4'b0010,0,0);
    MRD     = o(1,1,0,0,0,0,0,0,2'b00,2'b00,0,4'b0000,0,0);
    MWB     = o(0,0,0,0,0,1,1,0,2'b00,2'b00,0,4'b0000,1,0);
    MWR_W   = o(1,1,1,0,0,0,0,0,2'b00,2'b00,0,4'b0000,0,0);
    MWR_D   = o(1,1,1,0,0,0,0,0,2'b00,2'b00,0,4'b0000,1,0);
    BR_T    = o(0,0,0,0,0,0,0,1,2'b00,2'b01,1,4'b0110,1,0);
    BR_N    = o(0,0,0,0,0,0,0,1,2'b00,2'b01,0,4'b0110,1,0);
    ALUWB   = o(0,0,0,0,1,0,1,0,2'b00,2'b00,0,4'b0000,1,0);
    ADDX    = o(0,0,0,0,0,0,0,1,2'b10,2'b00,0,4'b0010,0,0);
    ADDWB   = o(0,0,0,0,0,0,1,0,2'b00,2'b00,0,4'b0000,1,0);
    JMP     = o(0,0,0,0,0,0,0,0,2'b00,2'b10,1,4'b0000,1,0);

    add("reset0", 0, 6'b101011, 6'd0, 0, 1, ZERO);
    add("reset1", 0, 6'b101011, 6'd0, 0, 1, ZERO);
    // lw, memory always ready: 5 cycles
    add("lw_fetch",  1, 6'b100011, 6'd0, 0, 1, F_RDY);
    add("lw_decode", 1, 6'b100011, 6'd0, 0, 1, DEC);
    add("lw_memadr", 1, 6'b100011, 6'd0, 0, 1, MADR);
    add("lw_memrd",  1, 6'b100011, 6'd0, 0, 1, MRD);
    add("lw_memwb",  1, 6'b100011, 6'd0, 0, 1, MWB);
    // sw with one fetch wait, then three MEMWR waits
    add("sw_fwait",  1, 6'b101011, 6'd0, 0, 0, F_WAIT);
    add("sw_fetch",  1, 6'b101011, 6'd0, 0, 1, F_RDY);
    add("sw_decode", 1, 6'b101011, 6'd0, 0, 1, DEC);
    add("sw_memadr", 1, 6'b101011, 6'd0, 0, 0, MADR);
    add("sw_wait1",  1, 6'b101011, 6'd0, 0, 0, MWR_W);
    add("sw_wait2",  1, 6'b101011, 6'd0, 0, 0, MWR_W);
    add("sw_wait3",  1, 6'b101011, 6'd0, 0, 0, MWR_W);
    add("sw_done",   1, 6'b101011, 6'd0, 0, 1, MWR_D);
    // branches
    add("beq_fetch", 1, 6'b000100, 6'd0, 1, 1, F_RDY);
    add("beq_dec",   1, 6'b000100, 6'd0, 1, 1, DEC);
    add("beq_z1",    1, 6'b000100, 6'd0, 1, 1, BR_T);
    add("bne_fetch", 1, 6'b000101, 6'd0, 1, 1, F_RDY);
    add("bne_dec",   1, 6'b000101, 6'd0, 1, 1, DEC);
    add("bne_z1",    1, 6'b000101, 6'd0, 1, 1, BR_N);
    add("bne_fetch2",1, 6'b000101, 6'd0, 0, 1, F_RDY);
    add("bne_dec2",  1, 6'b000101, 6'd0, 0, 1, DEC);
    add("bne_z0",    1, 6'b000101, 6'd0, 0, 1, BR_T);
    add("beq_fetch2",1, 6'b000100, 6'd0, 0, 1, F_RDY);
    add("beq_dec2",  1, 6'b000100, 6'd0, 0, 1, DEC);
    add("beq_z0",    1, 6'b000100, 6'd0, 0, 1, BR_N);
    // R-type: slt, or, unknown funct
    add("slt_fetch", 1, 6'b000000, 6'b101010, 0, 1, F_RDY);
    add("slt_dec",   1, 6'b000000, 6'b101010, 0, 1, DEC);
    add("slt_exec",  1, 6'b000000, 6'b101010, 0, 1, o(0,0,0,0,0,0,0,1,2'b00,2'b00,0,4'b0111,0,0));
    add("slt_wb",    1, 6'b000000, 6'b101010, 0, 1, ALUWB);
    add("or_fetch",  1, 6'b000000, 6'b100101, 0, 1, F_RDY);
    add("or_dec",    1, 6'b000000, 6'b100101, 0, 1, DEC);
    add("or_exec",   1, 6'b000000, 6'b100101, 0, 1, o(0,0,0,0,0,0,0,1,2'b00,2'b00,0,4'b0001,0,0));
    add("or_wb",     1, 6'b000000, 6'b100101, 0, 1, ALUWB);
    add("sub_fetch", 1, 6'b000000, 6'b100010, 0, 1, F_RDY);
    add("sub_dec",   1, 6'b000000, 6'b100010, 0, 1, DEC);
    add("sub_exec",  1, 6'b000000, 6'b100010, 0, 1, o(0,0,0,0,0,0,0,1,2'b00,2'b00,0,4'b0110,0,0));
    add("sub_wb",    1, 6'b000000, 6'b100010, 0, 1, ALUWB);
    add("unk_fetch", 1, 6'b000000, 6'b111111, 0, 1, F_RDY);
    add("unk_dec",   1, 6'b000000, 6'b111111, 0, 1, DEC);
    add("unk_exec",  1, 6'b000000, 6'b111111, 0, 1, o(0,0,0,0,0,0,0,1,2'b00,2'b00,0,4'b0000,0,0));
    add("unk_wb",    1, 6'b000000, 6'b111111, 0, 1, ALUWB);
    // addi, j
    add("addi_fetch",1, 6'b001000, 6'd0, 0, 1, F_RDY);
    add("addi_dec",  1, 6'b001000, 6'd0, 0, 1, DEC);
    add("addi_exec", 1, 6'b001000, 6'd0, 0, 1, ADDX);
    add("addi_wb",   1, 6'b001000, 6'd0, 0, 1, ADDWB);
    add("j_fetch",   1, 6'b000010, 6'd0, 0, 1, F_RDY);
    add("j_dec",     1, 6'b000010, 6'd0, 0, 1, DEC);
    add("j_jump",    1, 6'b000010, 6'd0, 0, 1, JMP);
    // illegal opcode
    add("ill_fetch", 1, 6'b111111, 6'd0, 0, 1, F_RDY);
    add("ill_dec",   1, 6'b111111, 6'd0, 0, 1, DEC_ILL);
    add("ill_next",  1, 6'b111111, 6'd0, 0, 0, F_WAIT);

    for (int i = 0; i < vecs.size(); i++)
      step_main(vecs[i].nm, vecs[i].rst_n, vecs[i].op, vecs[i].funct,
                vecs[i].zero, vecs[i].rdy, vecs[i].exp);

    // Reset asserted for two cycles while a store is stalled in MEMWR
    step_main("rst_sw_fetch", 1, 6'b101011, 6'd0, 0, 1, F_RDY);
    step_main("rst_sw_dec",   1, 6'b101011, 6'd0, 0, 1, DEC);
    step_main("rst_sw_adr",   1, 6'b101011, 6'd0, 0, 0, MADR);
    step_main("rst_sw_wait",  1, 6'b101011, 6'd0, 0, 0, MWR_W);
    step_main("rst_mid_1",    0, 6'b101011, 6'd0, 0, 0, ZERO);
    step_main("rst_mid_2",    0, 6'b101011, 6'd0, 0, 1, ZERO);
    step_main("rst_after",    1, 6'b101011, 6'd0, 0, 0, F_WAIT);
    step_main("rst_refetch",  1, 6'b100011, 6'd0, 0, 1, F_RDY);
    step_main("rst_redec",    1, 6'b100011, 6'd0, 0, 1, DEC);

    // SUPPORT_BNE=0, ALUCTRL_W=3: bne is an illegal opcode
    step_nb("nb_reset",  0, 6'b000101, 1, ZERO);
    step_nb("nb_fetch",  1, 6'b000101, 1, F_RDY);
    step_nb("nb_dec",    1, 6'b000101, 1, DEC_ILL);
    step_nb("nb_next",   1, 6'b000101, 0, F_WAIT);
    step_nb("nb_fetch2", 1, 6'b111111, 1, F_RDY);
    step_nb("nb_dec2",   1, 6'b111111, 1, DEC_ILL);
    step_nb("nb_next2",  1, 6'b111111, 0, F_WAIT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
